// File: rtl/fpdiv_iter.sv
// Iterative IEEE-754 single-precision divider (res = a / b), restoring radix-2 core
// with one quotient bit per clock. Flush-to-zero, round-half-up on the guard bit.
module fpdiv_iter #(
    parameter bit ZDIV_INF = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] res
);

    typedef enum logic [1:0] {IDLE, DIV, NORM} state_t;

    state_t             state_reg, state_next;
    logic [4:0]         cnt_reg;
    logic               sign_reg;
    logic signed [9:0]  exp_reg;
    logic [23:0]        mb_reg;
    logic [24:0]        rem_reg;
    logic [25:0]        q_reg;
    logic               az_reg, bz_reg;
    logic               done_reg;
    logic [31:0]        res_reg;

    logic               capture;
    logic               rem_ge;
    logic [24:0]        rem_step;
    logic [24:0]        m_rnd;
    logic signed [9:0]  exp_adj, exp_fin;
    logic [22:0]        mant_fin;
    logic [31:0]        res_calc;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        case (state_reg)
            IDLE: if (start) begin
                state_next = DIV;
                capture    = 1'b1;
            end
            DIV:  if (cnt_reg == 5'd25) state_next = NORM;
            NORM: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Restoring step: the remainder stays below mb, so the shifted value fits 25 bits.
    always_comb begin
        rem_ge   = (rem_reg >= {1'b0, mb_reg});
        rem_step = rem_ge ? (rem_reg - {1'b0, mb_reg}) : rem_reg;
    end

    always_comb begin
        if (q_reg[25]) begin
            m_rnd   = {1'b0, q_reg[25:2]} + 25'(q_reg[1]);
            exp_adj = exp_reg;
        end else begin
            m_rnd   = {1'b0, q_reg[24:1]} + 25'(q_reg[0]);
            exp_adj = exp_reg - 10'sd1;
        end
        // Rounding carry out of the mantissa renormalises to 1.0 x 2^(e+1).
        if (m_rnd[24]) begin
            exp_fin  = exp_adj + 10'sd1;
            mant_fin = 23'h0;
        end else begin
            exp_fin  = exp_adj;
            mant_fin = m_rnd[22:0];
        end

        if (az_reg && bz_reg)
            res_calc = ZDIV_INF ? 32'h7FC0_0000 : 32'h0;
        else if (az_reg)
            res_calc = 32'h0;
        else if (bz_reg)
            res_calc = ZDIV_INF ? {sign_reg, 8'hFF, 23'h0} : {sign_reg, 31'h0};
        else if (exp_fin >= 10'sd255)
            res_calc = {sign_reg, 8'hFF, 23'h0};
        else if (exp_fin <= 10'sd0)
            res_calc = 32'h0;
        else
            res_calc = {sign_reg, exp_fin[7:0], mant_fin};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            sign_reg  <= 1'b0;
            exp_reg   <= 10'sd0;
            mb_reg    <= 24'h0;
            rem_reg   <= 25'h0;
            q_reg     <= 26'h0;
            az_reg    <= 1'b0;
            bz_reg    <= 1'b0;
            done_reg  <= 1'b0;
            res_reg   <= 32'h0;
        end else begin
            state_reg <= state_next;
            done_reg  <= (state_reg == NORM);
            if (capture) begin
                sign_reg <= a[31] ^ b[31];
                exp_reg  <= signed'({2'b0, a[30:23]} - {2'b0, b[30:23]} + 10'd127);
                mb_reg   <= {1'b1, b[22:0]};
                rem_reg  <= {1'b0, 1'b1, a[22:0]};
                q_reg    <= 26'h0;
                az_reg   <= (a[30:23] == 8'h0);
                bz_reg   <= (b[30:23] == 8'h0);
                cnt_reg  <= 5'd0;
            end else if (state_reg == DIV) begin
                rem_reg  <= {rem_step[23:0], 1'b0};
                q_reg    <= {q_reg[24:0], rem_ge};
                cnt_reg  <= cnt_reg + 5'd1;
            end
            if (state_reg == NORM)
                res_reg <= res_calc;
        end
    end

    assign busy = (state_reg != IDLE);
    assign done = done_reg;
    assign res  = res_reg;

endmodule

// File: tb/tb_fpdiv_iter.sv
// Scoreboard bench for fpdiv_iter: two instances (ZDIV_INF=1 and 0) share stimulus;
// a monitor pops expected results whenever done is seen and checks value and latency.
module tb_fpdiv_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = 32'h0, b = 32'h0;
    logic        busy1, done1, busy0, done0;
    logic [31:0] res1, res0;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_seen = 0;

    typedef struct {
        logic [31:0] e1;
        logic [31:0] e0;
        int          issue;
        string       name;
    } exp_t;
    exp_t sb[$];

    fpdiv_iter #(.ZDIV_INF(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy1), .done(done1), .res(res1)
    );
    fpdiv_iter #(.ZDIV_INF(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy0), .done(done0), .res(res0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: cycle 1 is the clock period following the sampling edge, so done lands in cycle 28.
    always @(negedge clk) begin
        if (rst && done1) begin
            exp_t e;
            int   lat;
            done_seen++;
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done cyc=%0d res=%08h required no done", cyc, res1);
            end else begin
                e   = sb.pop_front();
                lat = cyc - e.issue + 1;
                checks++;
                if (res1 !== e.e1) begin
                    failures++;
                    $display("FAIL %s res(ZDIV_INF=1) got=%08h exp=%08h", e.name, res1, e.e1);
                end
                checks++;
                if (done0 !== 1'b1 || res0 !== e.e0) begin
                    failures++;
                    $display("FAIL %s res(ZDIV_INF=0) got=%08h done=%b exp=%08h", e.name, res0, done0, e.e0);
                end
                checks++;
                if (lat != 28) begin
                    failures++;
                    $display("FAIL %s latency got=%0d exp=28", e.name, lat);
                end
                $display("op %-10s a=%08h b=%08h res1=%08h res0=%08h lat=%0d", e.name, a, b, res1, res0, lat);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", nm, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] e1, input logic [31:0] e0, input string nm);
        exp_t e;
        @(negedge clk);
        a = ia; b = ib; start = 1'b1;
        @(posedge clk); #1;
        e.e1 = e1; e.e0 = e0; e.issue = cyc; e.name = nm;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int maxc, input string nm);
        for (int i = 0; i < maxc && sb.size() != 0; i++) @(posedge clk);
        @(negedge clk);
        check({nm, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    localparam int NV = 14;
    logic [31:0] va  [NV] = '{32'h40C00000, 32'h3F800000, 32'hBF800000, 32'h00000000,
                             32'h40A00000, 32'hC0A00000, 32'h00000000, 32'h00800000,
                             32'h7F000000, 32'h80000000, 32'h00400000, 32'h3F800000,
                             32'h40400000, 32'h40000000};
    logic [31:0] vb  [NV] = '{32'h40000000, 32'h40400000, 32'h40000000, 32'h40A00000,
                             32'h00000000, 32'h00000000, 32'h00000000, 32'h7F000000,
                             32'h00800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                             32'h3F800000, 32'hC0800000};
    logic [31:0] ve1 [NV] = '{32'h40400000, 32'h3EAAAAAB, 32'hBF000000, 32'h00000000,
                             32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h00000000,
                             32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                             32'h40400000, 32'hBF000000};
    logic [31:0] ve0 [NV] = '{32'h40400000, 32'h3EAAAAAB, 32'hBF000000, 32'h00000000,
                             32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000,
                             32'h7F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                             32'h40400000, 32'hBF000000};

    initial begin
        int bcnt;
        int seen_before;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", {31'h0, busy1}, 32'h0);
        check("reset_done", {31'h0, done1}, 32'h0);
        check("reset_res",  res1, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // 6.0/2.0 with busy-length measurement
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, "busy_6/2");
        bcnt = 1;  // the cycle right after the sampling edge was already busy
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done1) break;
            if (busy1) bcnt++;
        end
        check("busy_cycles", 32'(bcnt), 32'd27);
        wait_drain(40, "busy");

        for (int i = 0; i < NV; i++) begin
            issue(va[i], vb[i], ve1[i], ve0[i], $sformatf("vec%0d", i));
            wait_drain(40, $sformatf("vec%0d", i));
        end

        // start pulses during an op must not disturb it
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAB, "ignore");
        repeat (3) @(negedge clk);
        a = 32'h40C00000; b = 32'h40000000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'h7F000000; b = 32'h00800000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_drain(40, "ignore");
        seen_before = done_seen;
        repeat (40) @(negedge clk);
        check("ignore_no_extra_done", 32'(done_seen), 32'(seen_before));

        // start held high: ops accepted back-to-back every 28 clocks
        begin
            exp_t e;
            @(negedge clk);
            a = 32'hBF800000; b = 32'h40000000; start = 1'b1;
            @(posedge clk); #1;
            e.e1 = 32'hBF000000; e.e0 = 32'hBF000000; e.issue = cyc; e.name = "held0";
            sb.push_back(e);
            for (int k = 1; k < 3; k++) begin
                repeat (28) @(posedge clk);
                #1;
                e.issue = cyc; e.name = $sformatf("held%0d", k);
                sb.push_back(e);
            end
            @(negedge clk);
            start = 1'b0;
        end
        wait_drain(100, "held");

        // reset mid-operation
        issue(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, "pre_rst");
        wait_drain(40, "pre_rst");
        @(negedge clk);
        a = 32'h3F800000; b = 32'h40400000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midop_busy", {31'h0, busy1}, 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_busy", {31'h0, busy1}, 32'h0);
        check("rst_done", {31'h0, done1}, 32'h0);
        check("rst_res",  res1, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        seen_before = done_seen;
        repeat (40) @(negedge clk);
        check("rst_no_done", 32'(done_seen), 32'(seen_before));
        issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 32'h3EAAAAAB, "post_rst");
        wait_drain(40, "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
